// File: rtl/memory_pkg.sv
// Shared memory bus widths and command/data types.
// Imported by the request controller, its interface and the bench.
package memory_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 4;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } mem_cmd_t;

    typedef logic [DATA_WIDTH-1:0] mem_data_t;
endpackage

// File: rtl/memory_req_ctrl_if.sv
// Host request/response handshake and memory pin bundle.
// slave = controller view, master = host/memory view.
interface memory_req_ctrl_if;
    import memory_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    mem_data_t             req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    mem_data_t             rsp_data;
    logic                  mem_en;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    mem_data_t             mem_data_in;
    logic                  mem_vld_out;
    mem_data_t             mem_data_out;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        input  rsp_ready, mem_vld_out, mem_data_out,
        output req_ready, rsp_valid, rsp_data,
        output mem_en, mem_wr, mem_addr, mem_data_in
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        output rsp_ready, mem_vld_out, mem_data_out,
        input  req_ready, rsp_valid, rsp_data,
        input  mem_en, mem_wr, mem_addr, mem_data_in
    );
endinterface

// File: rtl/memory_ctrl_fifo.sv
// First-word-fall-through FIFO, power-of-2 depth.
// Pointers carry one wrap bit to tell full from empty.
module memory_ctrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic [WIDTH-1:0] store [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign count   = wp - rp;
    assign dout    = store[rp[AW-1:0]];
    assign do_pop  = pop && !empty;
    // A pop frees the slot, so a push into a full FIFO is fine then.
    assign do_push = push && (!full || do_pop);

    // Pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) store[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/memory_req_ctrl.sv
// In-order request front-end for the memory block.
// Reads are issued only against a free response slot.
module memory_req_ctrl
    import memory_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic                memory_clk,
    input  logic                memory_rst,
    memory_req_ctrl_if.slave    bus,
    output logic                busy,
    output logic                err_unexpected_vld
);
    localparam int OW = $clog2(RSP_DEPTH + 1);
    localparam int CW = $clog2(CMD_DEPTH + 1);
    localparam int CMD_W = $bits(mem_cmd_t);
    localparam logic [OW:0] RSP_LIM = RSP_DEPTH[OW:0];

    mem_cmd_t      cmd_in;
    mem_cmd_t      cmd_head;
    logic          cmd_full;
    logic          cmd_empty;
    logic [CW-1:0] cmd_count;
    logic          cmd_push;
    logic          issue;
    logic          rd_issue;
    logic          credit_ok;
    logic [OW-1:0] outstanding;
    mem_data_t     rsp_head;
    logic          rsp_full;
    logic          rsp_empty;
    logic [OW-1:0] rsp_count;
    logic          rsp_push;
    logic          rsp_pop;
    logic          vld_ok;

    assign bus.req_ready = memory_rst && !cmd_full;
    assign cmd_push      = bus.req_valid && bus.req_ready;
    assign cmd_in        = '{wr: bus.req_wr, addr: bus.req_addr,
                             data: bus.req_wdata};

    memory_ctrl_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (memory_clk),
        .rst_n (memory_rst),
        .push  (cmd_push),
        .din   (cmd_in),
        .pop   (issue),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    assign credit_ok = ({1'b0, outstanding} + {1'b0, rsp_count}) < RSP_LIM;
    assign issue     = !cmd_empty && (cmd_head.wr || credit_ok);
    assign rd_issue  = issue && !cmd_head.wr;

    assign vld_ok   = bus.mem_vld_out && (outstanding != '0);
    assign rsp_pop  = !rsp_empty && bus.rsp_ready;
    assign rsp_push = vld_ok && (!rsp_full || rsp_pop);

    memory_ctrl_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (memory_clk),
        .rst_n (memory_rst),
        .push  (rsp_push),
        .din   (bus.mem_data_out),
        .pop   (rsp_pop),
        .dout  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    assign bus.rsp_valid = !rsp_empty;
    assign bus.rsp_data  = rsp_head;

    assign busy = (cmd_count != '0) | bus.mem_en
                | (outstanding != '0) | bus.rsp_valid;

    // Registered memory pins: one-cycle pulse per issued command.
    always_ff @(posedge memory_clk or negedge memory_rst) begin
        if (!memory_rst) begin
            bus.mem_en      <= 1'b0;
            bus.mem_wr      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_data_in <= '0;
        end else if (issue) begin
            bus.mem_en      <= 1'b1;
            bus.mem_wr      <= cmd_head.wr;
            bus.mem_addr    <= cmd_head.addr;
            bus.mem_data_in <= cmd_head.wr ? cmd_head.data : '0;
        end else begin
            bus.mem_en      <= 1'b0;
            bus.mem_wr      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_data_in <= '0;
        end
    end

    // Reads in flight; issue and return on one edge cancel out.
    always_ff @(posedge memory_clk or negedge memory_rst) begin
        if (!memory_rst) begin
            outstanding <= '0;
        end else begin
            unique case ({rd_issue, vld_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky flag for a return with nothing outstanding.
    always_ff @(posedge memory_clk or negedge memory_rst) begin
        if (!memory_rst) begin
            err_unexpected_vld <= 1'b0;
        end else if (bus.mem_vld_out && (outstanding == '0)) begin
            err_unexpected_vld <= 1'b1;
        end
    end
endmodule

// File: tb/tb_memory_req_ctrl.sv
// Scoreboard bench for memory_req_ctrl with a behavioural memory.
// Expected issues and read data are queued at request acceptance.
module tb_memory_req_ctrl;
    import memory_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err;

    memory_req_ctrl_if mif ();

    memory_req_ctrl #(.CMD_DEPTH(4), .RSP_DEPTH(4)) dut (
        .memory_clk         (clk),
        .memory_rst         (rst_n),
        .bus                (mif.slave),
        .busy               (busy),
        .err_unexpected_vld (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_issue = 0;
    int icyc[$];
    logic [36:0] mem_exp[$];
    logic [31:0] rsp_exp[$];

    mem_data_t mem_arr [16];
    logic [3:0] pend[$];
    logic hold = 1'b0;
    logic force_vld = 1'b0;
    logic model_vld = 1'b0;
    mem_data_t model_data = '0;

    assign mif.mem_vld_out  = model_vld | force_vld;
    assign mif.mem_data_out = model_data;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory model: writes land at once, reads return one cycle later
    // unless hold parks them.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            model_vld = 1'b0;
        end else begin
            if (mif.mem_en) begin
                if (mif.mem_wr) mem_arr[mif.mem_addr] = mif.mem_data_in;
                else pend.push_back(mif.mem_addr);
            end
            if (!hold && pend.size() > 0) begin
                model_vld = 1'b1;
                model_data = mem_arr[pend.pop_front()];
            end else begin
                model_vld = 1'b0;
            end
        end
    end

    // Issue monitor.
    always @(negedge clk) begin
        if (rst_n && mif.mem_en) begin
            n_issue++;
            icyc.push_back(cyc);
            if (mem_exp.size() == 0) chk("issue_unexpected", 1, 0);
            else chk("issue", {mif.mem_wr, mif.mem_addr, mif.mem_data_in},
                     mem_exp.pop_front());
        end else if (rst_n) begin
            chk("idle_pins", {mif.mem_wr, mif.mem_addr, mif.mem_data_in}, 0);
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n && mif.rsp_valid && mif.rsp_ready) begin
            if (rsp_exp.size() == 0) chk("rsp_unexpected", 1, 0);
            else chk("rsp_data", mif.rsp_data, rsp_exp.pop_front());
        end
    end

    task automatic send(input logic wr, input logic [3:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rsp);
        logic acc = 1'b0;
        int n = 0;
        mif.req_valid = 1'b1;
        mif.req_wr = wr;
        mif.req_addr = a;
        mif.req_wdata = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = mif.req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accept", acc, 1);
        if (acc) begin
            mem_exp.push_back({wr, a, wr ? d : 32'h0});
            if (!wr) rsp_exp.push_back(exp_rsp);
        end
        mif.req_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_exp.size() != 0 || mem_exp.size() != 0 || busy)
               && n < 500) begin
            cycles(1);
            n++;
        end
        chk("drain", n < 500, 1);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 16; i++) mem_arr[i] = 32'h10 + i;
        mif.req_valid = 1'b0;
        mif.req_wr = 1'b0;
        mif.req_addr = '0;
        mif.req_wdata = '0;
        mif.rsp_ready = 1'b0;
        #1;
        chk("rst_mem_en", mif.mem_en, 0);
        chk("rst_req_ready", mif.req_ready, 0);
        chk("rst_rsp_valid", mif.rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        cycles(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", mif.req_ready, 1);
        cycles(1);

        // Response backpressure: credits exhausted, fifth read parks.
        base = n_issue;
        for (int i = 0; i < 4; i++) send(0, 4'(i), 0, 32'h10 + i);
        send(0, 4'd4, 0, 32'h14);
        cycles(6);
        chk("t3_issued", n_issue - base, 4);
        chk("t3_rsp_valid", mif.rsp_valid, 1);
        mif.rsp_ready = 1'b1;
        drain();
        chk("t3_issued_all", n_issue - base, 5);

        // Command backpressure: memory silent, host not accepting.
        mif.rsp_ready = 1'b0;
        hold = 1'b1;
        base = n_issue;
        for (int i = 0; i < 8; i++) send(0, 4'(5 + i), 0, 32'h15 + i);
        cycles(6);
        chk("t2_issued", n_issue - base, 4);
        @(negedge clk);
        chk("t2_req_ready", mif.req_ready, 0);
        chk("t2_busy", busy, 1);
        hold = 1'b0;
        cycles(8);
        chk("t2_still_full", mif.req_ready, 0);
        chk("t2_no_issue", n_issue - base, 4);
        mif.rsp_ready = 1'b1;
        send(0, 4'd13, 0, 32'h1d);
        drain();
        chk("t2_issued_all", n_issue - base, 9);

        // Write then read the same address.
        icyc.delete();
        send(1, 4'd3, 32'hdeadbeef, 0);
        send(0, 4'd3, 0, 32'hdeadbeef);
        drain();
        chk("t1_n", icyc.size(), 2);
        if (icyc.size() == 2) chk("t1_consec", icyc[1] - icyc[0], 1);
        chk("t1_busy", busy, 0);

        // Streaming reads, no bubbles.
        icyc.delete();
        for (int i = 0; i < 8; i++) send(0, 4'(8 + i), 0, 32'h18 + i);
        drain();
        chk("t4_n", icyc.size(), 8);
        if (icyc.size() == 8) chk("t4_span", icyc[7] - icyc[0], 7);

        // Return while idle.
        chk("t5_err_before", err, 0);
        force_vld = 1'b1;
        cycles(1);
        force_vld = 1'b0;
        @(negedge clk);
        chk("t5_err_set", err, 1);
        chk("t5_rsp_valid", mif.rsp_valid, 0);
        cycles(5);
        chk("t5_err_sticky", err, 1);

        // Reset with queued commands and reads in flight.
        mif.rsp_ready = 1'b0;
        send(0, 4'd0, 0, 32'h10);
        send(0, 4'd1, 0, 32'h11);
        cycles(4);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) send(0, 4'(2 + i), 0, 32'h12 + i);
        cycles(3);
        chk("t6_busy", busy, 1);
        chk("t6_rsp_valid", mif.rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_mem_en", mif.mem_en, 0);
        chk("t6_pins", {mif.mem_wr, mif.mem_addr, mif.mem_data_in}, 0);
        chk("t6_rsp_valid0", mif.rsp_valid, 0);
        chk("t6_busy0", busy, 0);
        chk("t6_err0", err, 0);
        chk("t6_req_ready0", mif.req_ready, 0);
        mem_exp.delete();
        rsp_exp.delete();
        hold = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_after", mif.req_ready, 1);
        chk("t6_busy_after", busy, 0);
        cycles(1);
        mif.rsp_ready = 1'b1;
        send(0, 4'd3, 0, 32'hdeadbeef);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_req_ctrl.md
Name: memory_req_ctrl

Overview:
Request front-end that sits directly upstream of the memory block and drives its memory_en/wr/addr/data_in pins. It accepts host read/write requests over a valid/ready handshake and buffers them in a command FIFO. It issues them to the memory in order, one per cycle. It captures memory_vld_out/memory_data_out into a response FIFO and returns read data to the host under valid/ready, with credit-based flow control so no read data is ever dropped.

Parameters:
DATA_WIDTH, 32, data bus width, shared with memory.
ADDR_WIDTH, 4, address width, shared with memory.
CMD_DEPTH, 4, command FIFO entries; must be a power of 2 and ≥2.
RSP_DEPTH, 4, response FIFO entries; must be a power of 2 and ≥2.

Ports:
memory_clk  in  1  single clock, rising edge.
memory_rst  in  1  asynchronous, active-low reset.
req_valid  in  1  host request valid.
req_ready  out  1  command FIFO can accept a request.
req_wr  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  request address.
req_wdata  in  DATA_WIDTH  write data; ignored for reads.
rsp_valid  out  1  read data available.
rsp_ready  in  1  host accepts read data.
rsp_data  out  DATA_WIDTH  read data at the response FIFO head.
mem_en  out  1  to memory_en.
mem_wr  out  1  to memory_wr.
mem_addr  out  ADDR_WIDTH  to memory_addr.
mem_data_in  out  DATA_WIDTH  to memory_data_in.
mem_vld_out  in  1  from memory_vld_out.
mem_data_out  in  DATA_WIDTH  from memory_data_out.
busy  out  1  work pending.
err_unexpected_vld  out  1  sticky protocol error flag.

Behaviour:
- Reset (memory_rst=0, async):
  - Both FIFOs empty; outstanding counter = 0.
  - mem_en, mem_wr, mem_addr, mem_data_in = 0.
  - rsp_valid = 0, busy = 0, err_unexpected_vld = 0.
  - req_ready = 0 while reset is asserted.
- Request accept: on an edge with req_valid && req_ready, {wr, addr, wdata} is pushed to the command FIFO.
  - req_ready = !cmd_full. It is combinational from registered state only, with no path from req_valid.
- Issue: at each edge, the FIFO head is popped and loaded into the registered mem_* outputs when both hold:
  - the command FIFO is non-empty; and
  - the head is a write, or (outstanding + rsp_count) < RSP_DEPTH (read credit available).
- Issued outputs:
  - mem_en = 1 for exactly one cycle per command.
  - mem_wr = cmd.wr, mem_addr = cmd.addr.
  - mem_data_in = wdata for writes, 0 for reads.
  - With no issue: mem_en = 0, mem_wr = 0, mem_addr and mem_data_in = 0.
- Latency: a request accepted at edge E appears on mem_* after edge E+1 at the earliest; throughput is 1 command/cycle.
- Ordering: strict FIFO order. A read stalled for credit blocks all younger commands, including writes, so read-after-write order is preserved.
- Outstanding counter (width $clog2(RSP_DEPTH+1)):
  - +1 when a read is issued.
  - −1 when mem_vld_out is sampled high while outstanding > 0.
  - Simultaneous issue and return leaves it unchanged.
  - It never exceeds RSP_DEPTH.
- Response capture: mem_vld_out=1 with outstanding > 0 pushes mem_data_out into the response FIFO.
  - The credit rule guarantees the FIFO is never full at that moment.
  - mem_vld_out=1 with outstanding = 0 is discarded and sets err_unexpected_vld; the flag is cleared only by reset.
  - Write commands never expect mem_vld_out.
- Response output: the response FIFO is first-word-fall-through.
  - rsp_valid = !rsp_empty; rsp_data = head.
  - A pop occurs on rsp_valid && rsp_ready.
  - Push and pop on the same edge is allowed, including when the FIFO is full.
- busy = !cmd_empty | mem_en | (outstanding ≠ 0) | rsp_valid.
- FIFO pointers are ADDR bits plus 1 wrap bit.
  - full = equal indices with the wrap bit differing; empty = pointers equal.
  - Pointers wrap modulo 2·DEPTH.
- Reset mid-operation: all queued commands, outstanding reads and buffered responses are discarded. The memory shares memory_rst, so no late vld arrives.

Decomposition:
- memory_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH constants, already used by memory.
  - typedef struct packed mem_cmd_t {logic wr; logic [ADDR_WIDTH-1:0] addr; logic [DATA_WIDTH-1:0] data;}.
  - typedef logic [DATA_WIDTH-1:0] mem_data_t.
- One sub-module, memory_ctrl_fifo: a parameterised (WIDTH, DEPTH) synchronous FWFT FIFO with full, empty and count outputs. It is instantiated twice, once as the command FIFO and once as the response FIFO.

Test Plan:
1. Write then read: write addr 3 data 0xDEADBEEF, then read addr 3, rsp_ready=1 → mem_en pulses wr=1 then wr=0 on consecutive cycles; rsp_valid=1 with rsp_data=0xDEADBEEF; busy returns to 0.
2. Command backpressure: hold mem_vld_out low and rsp_ready=0, then issue 9 reads → exactly 4 reads reach mem_en (credit limit). The command FIFO fills (4), so req_ready=0 until responses drain.
3. Response backpressure: read addrs 0–3 (preloaded 0x10–0x13) with rsp_ready=0, then set rsp_ready=1 → 4 responses in order 0x10, 0x11, 0x12, 0x13; no further read is issued while credits = 0.
4. Simultaneous events: a steady stream of reads with rsp_ready=1 and 1-cycle memory latency → one mem_en per cycle; outstanding stays constant; no stall bubbles after fill.
5. Protocol error: pulse mem_vld_out while idle → err_unexpected_vld=1 and stays high; rsp_valid stays 0; the flag clears only on memory_rst=0.
6. Reset mid-operation: assert memory_rst with 3 commands queued and 2 reads outstanding → all outputs 0 immediately (async), rsp_valid=0; after release, req_ready=1 on the first cycle.
